layer_compositor_pipe: RTL

- Parametrised, pipelined successor to the fixed 6-layer RGB select. Picks one of NUM_LAYERS requesting layers per pixel by fixed priority, with optional colour-key transparency and a programmable background colour.
- Registered RGB output with valid; counts per-frame overlap conflicts for debug readback.
- Sits between the layer pattern generators and the display timing/output block.

---
 rtl/layer_compositor_pipe_if.sv | 41 ++++
 rtl/layer_compositor_pipe.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/layer_compositor_pipe_if.sv
// ---------------------------------------------------------------------------
// layer_compositor_pipe_if
// Bus between the layer pattern generators / frame control (master side) and
// the layer compositor (slave side).
//   Master -> slave : pix_valid_in, sof, layer_req, layer_pix, key_color,
//                     key_en_rt, bg_color
//   Slave -> master : pix_valid_out, red, green, blue, sel_idx, sel_none,
//                     conflict_cnt
// layer_pix packs {r,g,b} per layer, layer i at [(i+1)*3*CW-1 : i*3*CW].
// ---------------------------------------------------------------------------
interface layer_compositor_pipe_if #(
    parameter int NUM_LAYERS = 6,
    parameter int CW         = 8,
    parameter int IDXW       = $clog2(NUM_LAYERS)
);
    logic                       pix_valid_in;
    logic                       sof;
    logic [NUM_LAYERS-1:0]      layer_req;
    logic [NUM_LAYERS*3*CW-1:0] layer_pix;
    logic [3*CW-1:0]            key_color;
    logic                       key_en_rt;
    logic [3*CW-1:0]            bg_color;

    logic                       pix_valid_out;
    logic [CW-1:0]              red;
    logic [CW-1:0]              green;
    logic [CW-1:0]              blue;
    logic [IDXW-1:0]            sel_idx;
    logic                       sel_none;
    logic [15:0]                conflict_cnt;

    modport master (
        output pix_valid_in, sof, layer_req, layer_pix, key_color, key_en_rt, bg_color,
        input  pix_valid_out, red, green, blue, sel_idx, sel_none, conflict_cnt
    );

    modport slave (
        input  pix_valid_in, sof, layer_req, layer_pix, key_color, key_en_rt, bg_color,
        output pix_valid_out, red, green, blue, sel_idx, sel_none, conflict_cnt
    );
endinterface

// File: rtl/layer_compositor_pipe.sv
// ---------------------------------------------------------------------------
// layer_compositor_pipe
// Two-stage pixel compositor: per pixel, picks the lowest-index layer that
// requests the pixel and is not colour-keyed out; emits bg_color otherwise.
// Also counts, per frame, the pixels where two or more layers were eligible.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : layer_compositor_pipe_if.slave (pixel inputs, composited output,
//          selected index, background flag, previous-frame conflict count)
// Latency 2 clk, 1 pixel/clk, no backpressure.
// ---------------------------------------------------------------------------

// Per-layer colour-key comparator (one instance per layer).
module layer_key_cmp #(
    parameter int PW = 24
) (
    input  logic [PW-1:0] pix,
    input  logic [PW-1:0] key,
    input  logic          en,
    output logic          hit
);
    assign hit = en && (pix == key);
endmodule

module layer_compositor_pipe #(
    parameter int NUM_LAYERS = 6,
    parameter int CW         = 8,
    parameter int KEY_EN     = 1,
    parameter int IDXW       = $clog2(NUM_LAYERS)
) (
    input  logic                    clk,
    input  logic                    rst,
    layer_compositor_pipe_if.slave  bus
);
    localparam int PW     = 3 * CW;
    localparam int STAGES = 2;

    // ---------------- stage 1: eligibility + priority pick ----------------
    logic [NUM_LAYERS-1:0][PW-1:0] layerPix;
    logic [NUM_LAYERS-1:0]         keyHit;
    logic [NUM_LAYERS-1:0]         elig;
    logic                          keyOn;

    assign layerPix = bus.layer_pix;
    // With KEY_EN=0 this is constant 0 and the comparators fold away.
    assign keyOn    = (KEY_EN != 0) && bus.key_en_rt;

    genvar g;
    generate
        for (g = 0; g < NUM_LAYERS; g++) begin : gLane
            layer_key_cmp #(.PW(PW)) uKeyCmp (
                .pix (layerPix[g]),
                .key (bus.key_color),
                .en  (keyOn),
                .hit (keyHit[g])
            );
        end
    endgenerate

    assign elig = bus.layer_req & ~keyHit;

    logic [PW-1:0]   winPix;
    logic [IDXW-1:0] winIdx;
    logic            noneC;
    logic            multiC;

    // Scan from the lowest priority upward so the last hit (lowest index)
    // wins. Background is folded in here so stage 1 captures bg_color
    // together with the rest of the pixel's inputs.
    always_comb begin
        winPix = bus.bg_color;
        winIdx = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (elig[i]) begin
                winPix = layerPix[i];
                winIdx = IDXW'(i);
            end
        end
        noneC  = ~|elig;
        // Clearing the lowest set bit leaves something iff >=2 bits were set.
        multiC = |(elig & (elig - NUM_LAYERS'(1)));
    end

    logic [STAGES:1] vldPipe;
    logic [PW-1:0]   s1Pix;
    logic [IDXW-1:0] s1Idx;
    logic            s1None;
    logic            s1Multi;
    logic            s1Sof;

    always_ff @(posedge clk) begin
        if (rst) begin
            vldPipe <= '0;
            s1Pix   <= '0;
            s1Idx   <= '0;
            s1None  <= 1'b1;
            s1Multi <= 1'b0;
            s1Sof   <= 1'b0;
        end else begin
            vldPipe <= {vldPipe[STAGES-1:1], bus.pix_valid_in};
            if (bus.pix_valid_in) begin
                s1Pix   <= winPix;
                s1Idx   <= winIdx;
                s1None  <= noneC;
                s1Multi <= multiC;
                s1Sof   <= bus.sof;
            end
        end
    end

    // ---------------- stage 2: output registers ----------------
    logic [PW-1:0]   outRgb;
    logic [IDXW-1:0] outIdx;
    logic            outNone;

    always_ff @(posedge clk) begin
        if (rst) begin
            outRgb  <= '0;
            outIdx  <= '0;
            outNone <= 1'b1;
        end else if (vldPipe[1]) begin
            outRgb  <= s1Pix;
            outIdx  <= s1Idx;
            outNone <= s1None;
        end
    end

    // ---------------- per-frame conflict counter ----------------
    // Driven from stage 1 so the reported total lands on the same edge that
    // the sof pixel reaches the outputs.
    logic [15:0] runCnt;
    logic [15:0] confCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            runCnt  <= '0;
            confCnt <= '0;
        end else if (vldPipe[1]) begin
            if (s1Sof) begin
                confCnt <= runCnt;
                runCnt  <= {15'd0, s1Multi};  // sof pixel belongs to the new frame
            end else if (s1Multi && runCnt != 16'hFFFF) begin
                runCnt  <= runCnt + 16'd1;
            end
        end
    end

    assign bus.pix_valid_out = vldPipe[STAGES];
    assign bus.red           = outRgb[3*CW-1:2*CW];
    assign bus.green         = outRgb[2*CW-1:CW];
    assign bus.blue          = outRgb[CW-1:0];
    assign bus.sel_idx       = outIdx;
    assign bus.sel_none      = outNone;
    assign bus.conflict_cnt  = confCnt;

endmodule
